// File: rtl/sevenseg_pkg.sv
// sevenseg_pkg: shared constants, glyph table and FSM state type for the
// seven-segment capture path and the display driver self-check.
package sevenseg_pkg;

  localparam int unsigned DIGITS   = 4;
  localparam int unsigned NIBBLE_W = 4;
  localparam int unsigned SEG_W    = 7;

  // Active-high gfedcba patterns for hex digits 0..F.
  localparam logic [SEG_W-1:0] GLYPH_TABLE [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  typedef enum logic {
    ST_HUNT,
    ST_COLLECT
  } state_t;

endpackage

// File: rtl/sevenseg_capture_if.sv
// sevenseg_capture_if: display bus (anodes/segments) plus captured-frame
// outputs. Optional decimal-point lines under SEVENSEG_DP_EN.
interface sevenseg_capture_if;
  import sevenseg_pkg::*;

  logic [DIGITS-1:0]          an_i;
  logic [SEG_W-1:0]           seg_i;
  logic [DIGITS*NIBBLE_W-1:0] frame_o;
  logic                       frame_valid_o;
  logic                       seg_err_o;
  logic [1:0]                 digit_idx_o;
`ifdef SEVENSEG_DP_EN
  logic                       dp_i;
  logic [DIGITS-1:0]          dp_o;

  modport master (output an_i, seg_i, dp_i,
                  input  frame_o, frame_valid_o, seg_err_o, digit_idx_o, dp_o);
  modport slave  (input  an_i, seg_i, dp_i,
                  output frame_o, frame_valid_o, seg_err_o, digit_idx_o, dp_o);
`else
  modport master (output an_i, seg_i,
                  input  frame_o, frame_valid_o, seg_err_o, digit_idx_o);
  modport slave  (input  an_i, seg_i,
                  output frame_o, frame_valid_o, seg_err_o, digit_idx_o);
`endif

endinterface

// File: rtl/sevenseg_glyph_decode.sv
// sevenseg_glyph_decode: active-high gfedcba pattern to hex nibble with a
// legal flag; any pattern outside the glyph table is illegal.
module sevenseg_glyph_decode
  import sevenseg_pkg::*;
(
  input  logic [SEG_W-1:0]    i_pattern,
  output logic [NIBBLE_W-1:0] o_nibble,
  output logic                o_legal
);

  // Table search; glyphs are unique so at most one entry matches.
  always_comb begin
    o_nibble = '0;
    o_legal  = 1'b0;
    for (int unsigned i = 0; i < 16; i++) begin
      if (i_pattern == GLYPH_TABLE[i]) begin
        o_nibble = NIBBLE_W'(i);
        o_legal  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/sevenseg_capture.sv
// sevenseg_capture: rebuilds the 4-digit hex frame from a multiplexed
// seven-segment bus. Optional macro SEVENSEG_DP_EN adds per-digit decimal
// point capture (dp_i sampled with the bus, dp_o updated with frame_o).
module sevenseg_capture
  import sevenseg_pkg::*;
#(
  parameter int unsigned STABLE_CYCLES = 4,
  parameter int unsigned SYNC_STAGES   = 2
)(
  input  logic              system1000,
  input  logic              system1000_rstn,
  sevenseg_capture_if.slave bus
);

`ifdef SEVENSEG_DP_EN
  localparam int unsigned SAMPLE_W = SEG_W + DIGITS + 1;
`else
  localparam int unsigned SAMPLE_W = SEG_W + DIGITS;
`endif
  localparam logic [7:0] CNT_MAX = 8'(STABLE_CYCLES);

  logic [SAMPLE_W-1:0] w_pin;
  logic [SAMPLE_W-1:0] r_sync [SYNC_STAGES];
  logic [SAMPLE_W-1:0] w_s;
  logic [SAMPLE_W-1:0] r_p;
  logic [7:0]          r_cnt;
  logic                w_same;
  logic                w_accept;

  logic [DIGITS-1:0]   w_an_lo;
  logic                w_blank;
  logic                w_onehot;
  logic [1:0]          w_k;
  logic [SEG_W-1:0]    w_pattern;
  logic [NIBBLE_W-1:0] w_nibble;
  logic                w_legal;

  state_t                          r_state;
  logic [1:0]                      r_exp;
  logic                            r_bad;
  logic [DIGITS-1:0][NIBBLE_W-1:0] r_nib;
  logic [DIGITS*NIBBLE_W-1:0]      r_frame;
  logic                            r_frame_valid;
  logic                            r_seg_err;
  logic [1:0]                      r_idx;

`ifdef SEVENSEG_DP_EN
  logic                w_dp;
  logic [DIGITS-1:0]   r_dpd;
  logic [DIGITS-1:0]   r_dp_out;
  assign w_pin   = {bus.dp_i, bus.an_i, bus.seg_i};
  assign w_dp    = ~w_s[SEG_W+DIGITS];
  assign bus.dp_o = r_dp_out;
`else
  assign w_pin   = {bus.an_i, bus.seg_i};
`endif

  assign w_s = r_sync[SYNC_STAGES-1];

  // Pin synchroniser plus one-cycle delayed copy for change detection.
  always_ff @(posedge system1000 or negedge system1000_rstn) begin
    if (!system1000_rstn) begin
      for (int unsigned i = 0; i < SYNC_STAGES; i++) r_sync[i] <= '1;
      r_p <= '1;
    end else begin
      r_sync[0] <= w_pin;
      for (int unsigned i = 1; i < SYNC_STAGES; i++) r_sync[i] <= r_sync[i-1];
      r_p <= w_s;
    end
  end

  // r_cnt is the run length of S including the current sample; a change
  // starts a new run of one, so ACCEPT lands on the STABLE_CYCLES-th
  // identical sample and never repeats while the sample is held.
  assign w_same   = (w_s == r_p);
  assign w_accept = w_same && (r_cnt == CNT_MAX - 8'd1);

  // Stability run-length counter, saturating.
  always_ff @(posedge system1000 or negedge system1000_rstn) begin
    if (!system1000_rstn)      r_cnt <= '0;
    else if (!w_same)          r_cnt <= 8'd1;
    else if (r_cnt != CNT_MAX) r_cnt <= r_cnt + 8'd1;
  end

  assign w_an_lo   = ~w_s[SEG_W +: DIGITS];
  assign w_blank   = (w_an_lo == '0);
  assign w_onehot  = $onehot(w_an_lo);
  assign w_pattern = ~w_s[SEG_W-1:0];

  // Index of the active anode (meaningful only when exactly one is low).
  always_comb begin
    w_k = '0;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (w_an_lo[i]) w_k = 2'(i);
    end
  end

  sevenseg_glyph_decode u_decode (
    .i_pattern (w_pattern),
    .o_nibble  (w_nibble),
    .o_legal   (w_legal)
  );

  // Frame assembly FSM with registered outputs.
  always_ff @(posedge system1000 or negedge system1000_rstn) begin
    if (!system1000_rstn) begin
      r_state       <= ST_HUNT;
      r_exp         <= '0;
      r_bad         <= 1'b0;
      r_nib         <= '0;
      r_frame       <= '0;
      r_frame_valid <= 1'b0;
      r_seg_err     <= 1'b0;
      r_idx         <= '0;
`ifdef SEVENSEG_DP_EN
      r_dpd         <= '0;
      r_dp_out      <= '0;
`endif
    end else begin
      r_frame_valid <= 1'b0;
      r_seg_err     <= 1'b0;
      if (w_accept && !w_blank) begin
        if (!w_onehot) begin
          r_seg_err <= 1'b1;
          r_state   <= ST_HUNT;
        end else begin
          if (!w_legal) r_seg_err <= 1'b1;
          if ((r_state == ST_COLLECT) && (w_k == r_exp)) begin
            r_nib[w_k] <= w_nibble;
`ifdef SEVENSEG_DP_EN
            r_dpd[w_k] <= w_dp;
`endif
            r_idx      <= w_k;
            if (w_k == 2'd3) begin
              if (!r_bad && w_legal) begin
                r_frame       <= {w_nibble, r_nib[2], r_nib[1], r_nib[0]};
                r_frame_valid <= 1'b1;
`ifdef SEVENSEG_DP_EN
                r_dp_out      <= {w_dp, r_dpd[2:0]};
`endif
              end
              r_exp <= '0;
              r_bad <= 1'b0;
            end else begin
              r_exp <= r_exp + 2'd1;
              r_bad <= r_bad | ~w_legal;
            end
          end else if (w_k == 2'd0) begin
            // HUNT start and out-of-order restart share this path.
            r_nib[0] <= w_nibble;
`ifdef SEVENSEG_DP_EN
            r_dpd[0] <= w_dp;
`endif
            r_idx    <= 2'd0;
            r_exp    <= 2'd1;
            r_bad    <= ~w_legal;
            r_state  <= ST_COLLECT;
          end else begin
            r_state <= ST_HUNT;
          end
        end
      end
    end
  end

  assign bus.frame_o       = r_frame;
  assign bus.frame_valid_o = r_frame_valid;
  assign bus.seg_err_o     = r_seg_err;
  assign bus.digit_idx_o   = r_idx;

endmodule

// File: tb/tb_sevenseg_capture.sv
// tb_sevenseg_capture: directed scans on the multiplexed bus, checked every
// cycle against a frame-level reference model plus literal expectations.
module tb_sevenseg_capture;

  localparam int STABLE = 4;
  localparam int SYNC   = 2;

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  sevenseg_capture_if bus ();

  sevenseg_capture #(.STABLE_CYCLES(STABLE), .SYNC_STAGES(SYNC)) dut (
    .system1000      (clk),
    .system1000_rstn (rstn),
    .bus             (bus)
  );

  logic [6:0] glyph [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  int n_pass  = 0;
  int n_total = 0;
  int n_fv    = 0;
  int n_err   = 0;
  int fv0, e0;

  // Reference model state: pin delay line, run length of the synchronised
  // sample, and the digits collected so far in order.
  logic [10:0] m_dly [$];
  logic [10:0] m_prev, ms;
  int          m_run, mnew, mk;
  bit          macc, mlegal;
  logic [3:0]  man, mnib;
  logic [6:0]  mpat;
  logic [3:0]  m_part [$];
  bit          m_bad;
  logic [15:0] m_frame;
  bit          m_fv, m_err;
  logic [1:0]  m_idx;

  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      m_dly.delete();
      for (int i = 0; i < SYNC; i++) m_dly.push_back(11'h7FF);
      m_run = 0; m_prev = 11'h7FF;
      m_part.delete(); m_bad = 1'b0;
      m_frame = 16'h0; m_fv = 1'b0; m_err = 1'b0; m_idx = 2'd0;
    end else begin
      m_dly.push_back({bus.an_i, bus.seg_i});
      ms = m_dly.pop_front();
      m_fv = 1'b0; m_err = 1'b0;
      mnew = (m_run > 0 && ms == m_prev) ? ((m_run < STABLE) ? m_run + 1 : STABLE) : 1;
      macc = (mnew == STABLE) && (m_run == STABLE - 1);
      m_run = mnew; m_prev = ms;
      if (macc) begin
        man  = ms[10:7];
        mpat = ~ms[6:0];
        if (man != 4'hF) begin
          if ($countones(~man) > 1) begin
            m_err = 1'b1; m_part.delete(); m_bad = 1'b0;
          end else begin
            for (int i = 0; i < 4; i++) if (!man[i]) mk = i;
            mlegal = 1'b0; mnib = 4'h0;
            for (int g = 0; g < 16; g++) if (glyph[g] == mpat) begin mlegal = 1'b1; mnib = 4'(g); end
            if (!mlegal) m_err = 1'b1;
            if (mk != m_part.size()) begin
              m_part.delete(); m_bad = 1'b0;
            end
            if (mk == m_part.size()) begin
              m_part.push_back(mnib);
              m_bad = m_bad | !mlegal;
              m_idx = 2'(mk);
              if (m_part.size() == 4) begin
                if (!m_bad) begin
                  m_frame = {m_part[3], m_part[2], m_part[1], m_part[0]};
                  m_fv = 1'b1;
                end
                m_part.delete(); m_bad = 1'b0;
              end
            end
          end
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  task automatic drive(input logic [3:0] an, input logic [6:0] pat, input int n);
    bus.an_i  = an;
    bus.seg_i = ~pat;
    repeat (n) @(negedge clk);
  endtask

  task automatic digit(input int k, input int val, input int n);
    logic [3:0] an;
    an = ~(4'b0001 << k);
    drive(an, glyph[val], n);
  endtask

  task automatic idle(input int n);
    drive(4'hF, 7'h00, n);
  endtask

  task automatic scan(input int v0, input int v1, input int v2, input int v3);
    digit(0, v0, 8); digit(1, v1, 8); digit(2, v2, 8); digit(3, v3, 8);
  endtask

  initial begin
    bus.an_i  = 4'hF;
    bus.seg_i = 7'h7F;
    rstn      = 1'b0;
    fork
      forever begin
        @(negedge clk);
        check("frame_o",       bus.frame_o,       m_frame);
        check("frame_valid_o", bus.frame_valid_o, m_fv);
        check("seg_err_o",     bus.seg_err_o,     m_err);
        check("digit_idx_o",   bus.digit_idx_o,   m_idx);
        if (bus.frame_valid_o === 1'b1) n_fv++;
        if (bus.seg_err_o === 1'b1) n_err++;
      end
    join_none

    repeat (3) @(negedge clk);
    check("rst_frame", bus.frame_o, 16'h0000);
    check("rst_fv",    bus.frame_valid_o, 1'b0);
    check("rst_err",   bus.seg_err_o, 1'b0);
    check("rst_idx",   bus.digit_idx_o, 2'd0);
    rstn = 1'b1;
    idle(10);

    // 1: single frame 1,2,3,4
    fv0 = n_fv; e0 = n_err;
    scan(1, 2, 3, 4); idle(12);
    check("t1_pulses", n_fv - fv0, 1);
    check("t1_errs",   n_err - e0, 0);
    check("t1_frame",  bus.frame_o, 16'h4321);
    check("t1_model",  m_frame, 16'h4321);
    check("t1_idx",    bus.digit_idx_o, 2'd3);

    // 2: three back-to-back frames
    fv0 = n_fv; e0 = n_err;
    scan(5, 6, 7, 8); scan(9, 10, 11, 12); scan(13, 14, 15, 0); idle(12);
    check("t2_pulses", n_fv - fv0, 3);
    check("t2_errs",   n_err - e0, 0);
    check("t2_frame",  bus.frame_o, 16'h0FED);

    // 3: blank glyph on digit 2 spoils the frame; next frame is clean
    fv0 = n_fv; e0 = n_err;
    digit(0, 1, 8); digit(1, 1, 8); drive(4'b1011, 7'h00, 8); digit(3, 1, 8); idle(12);
    check("t3_bad_pulses", n_fv - fv0, 0);
    check("t3_bad_errs",   n_err - e0, 1);
    check("t3_hold_frame", bus.frame_o, 16'h0FED);
    scan(7, 8, 9, 10); idle(12);
    check("t3_pulses", n_fv - fv0, 1);
    check("t3_frame",  bus.frame_o, 16'hA987);

    // 4: skipped digit 2 drops the partial
    fv0 = n_fv; e0 = n_err;
    digit(0, 9, 8); digit(1, 9, 8); digit(3, 9, 8);
    scan(1, 0, 2, 3); idle(12);
    check("t4_pulses", n_fv - fv0, 1);
    check("t4_errs",   n_err - e0, 0);
    check("t4_frame",  bus.frame_o, 16'h3201);

    // 5: 2-cycle glitch at the start of digit 2 is never accepted
    fv0 = n_fv; e0 = n_err;
    digit(0, 10, 8); digit(1, 11, 8); digit(2, 8, 2); digit(2, 12, 8); digit(3, 13, 8); idle(12);
    check("t5_pulses", n_fv - fv0, 1);
    check("t5_errs",   n_err - e0, 0);
    check("t5_frame",  bus.frame_o, 16'hDCBA);

    // 6: reset during digit 2
    fv0 = n_fv; e0 = n_err;
    digit(0, 1, 8); digit(1, 2, 8); digit(2, 3, 6);
    #2 rstn = 1'b0;
    #1;
    check("t6_rst_frame", bus.frame_o, 16'h0000);
    check("t6_rst_idx",   bus.digit_idx_o, 2'd0);
    @(negedge clk); @(negedge clk);
    rstn = 1'b1;
    digit(2, 3, 2); digit(3, 4, 8); idle(12);
    check("t6_no_pulse", n_fv - fv0, 0);
    check("t6_frame0",   bus.frame_o, 16'h0000);
    scan(4, 5, 6, 7); idle(12);
    check("t6_pulses", n_fv - fv0, 1);
    check("t6_errs",   n_err - e0, 0);
    check("t6_frame",  bus.frame_o, 16'h7654);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
